fpu_issue: RTL and testbench

- Core-side initiator for the combinational FPU datapath. It accepts one FP operation per handshake and drives ctrl/ds_val/dt_val/dd/imm to the FPU.
- Operands are held stable for a per-opcode multicycle latency, since the FPU is a single combinational cloud timed as a multicycle path.
- After that latency it samples the FPU's reg_addr/dd_val and issues a one-cycle register-file writeback.
- It also exports the pending destination so the core can detect RAW hazards.

---
 rtl/fpu_issue_if.sv | 40 ++++
 rtl/fpu_issue.sv | 129 ++++++++++++
 tb/tb_fpu_issue.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/fpu_issue_if.sv
// Core-side request, FPU operand/result, writeback and hazard signals of fpu_issue.
// The master modport is the surrounding core/FPU side; the slave modport is fpu_issue.
interface fpu_issue_if;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_ctrl;
  logic [31:0] req_ds_val;
  logic [31:0] req_dt_val;
  logic [5:0]  req_dd;
  logic [15:0] req_imm;
  logic        flush;

  logic [3:0]  fpu_ctrl;
  logic [31:0] fpu_ds_val;
  logic [31:0] fpu_dt_val;
  logic [5:0]  fpu_dd;
  logic [15:0] fpu_imm;
  logic [5:0]  fpu_reg_addr;
  logic [31:0] fpu_dd_val;

  logic        wb_valid;
  logic [5:0]  wb_addr;
  logic [31:0] wb_data;
  logic        pend_valid;
  logic [5:0]  pend_addr;

  modport master (
    output req_valid, req_ctrl, req_ds_val, req_dt_val, req_dd, req_imm, flush,
    output fpu_reg_addr, fpu_dd_val,
    input  req_ready, fpu_ctrl, fpu_ds_val, fpu_dt_val, fpu_dd, fpu_imm,
    input  wb_valid, wb_addr, wb_data, pend_valid, pend_addr
  );

  modport slave (
    input  req_valid, req_ctrl, req_ds_val, req_dt_val, req_dd, req_imm, flush,
    input  fpu_reg_addr, fpu_dd_val,
    output req_ready, fpu_ctrl, fpu_ds_val, fpu_dt_val, fpu_dd, fpu_imm,
    output wb_valid, wb_addr, wb_data, pend_valid, pend_addr
  );
endinterface

// File: rtl/fpu_issue.sv
// Issues one op to the combinational FPU, holds operands for the opcode's multicycle
// latency, then samples the result and strobes a single-cycle register writeback.
module fpu_issue #(
  parameter int LAT_ADD  = 2,
  parameter int LAT_MUL  = 2,
  parameter int LAT_INV  = 4,
  parameter int LAT_SQRT = 4,
  parameter int LAT_CVT  = 2
) (
  input  logic        clk,
  input  logic        rstn,
  fpu_issue_if.slave  bus
);

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         hold_ctrl_q, hold_ctrl_d;
  logic [31:0]        hold_ds_q, hold_ds_d;
  logic [31:0]        hold_dt_q, hold_dt_d;
  logic [5:0]         hold_dd_q, hold_dd_d;
  logic [15:0]        hold_imm_q, hold_imm_d;
  logic [5:0]         wb_addr_q, wb_addr_d;
  logic [31:0]        wb_data_q, wb_data_d;
  logic               ready;
  logic               accept;

  // Counter preload is latency-1; a zero latency parameter still needs one EXEC cycle.
  function automatic logic [CNT_W-1:0] lat_m1(input logic [3:0] c);
    int l;
    case (c)
      4'd1, 4'd2:  l = LAT_ADD;
      4'd3:        l = LAT_MUL;
      4'd4:        l = LAT_INV;
      4'd5:        l = LAT_SQRT;
      4'd9, 4'd10: l = LAT_CVT;
      default:     l = 1;
    endcase
    if (l < 1) l = 1;
    return CNT_W'(l - 1);
  endfunction

  assign ready  = rstn && !bus.flush && (state_q == S_IDLE || state_q == S_WB);
  assign accept = bus.req_valid && ready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hold_ctrl_d = hold_ctrl_q;
    hold_ds_d   = hold_ds_q;
    hold_dt_d   = hold_dt_q;
    hold_dd_d   = hold_dd_q;
    hold_imm_d  = hold_imm_q;
    wb_addr_d   = wb_addr_q;
    wb_data_d   = wb_data_q;

    case (state_q)
      S_IDLE: state_d = S_IDLE;
      S_EXEC: begin
        if (bus.flush) begin
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          wb_addr_d = bus.fpu_reg_addr;
          wb_data_d = bus.fpu_dd_val;
          state_d   = S_WB;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Acceptance is only possible in IDLE or WB, so it overrides their default exit.
    if (accept) begin
      hold_ctrl_d = bus.req_ctrl;
      hold_ds_d   = bus.req_ds_val;
      hold_dt_d   = bus.req_dt_val;
      hold_dd_d   = bus.req_dd;
      hold_imm_d  = bus.req_imm;
      cnt_d       = lat_m1(bus.req_ctrl);
      state_d     = S_EXEC;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      hold_ctrl_q <= '0;
      hold_ds_q   <= '0;
      hold_dt_q   <= '0;
      hold_dd_q   <= '0;
      hold_imm_q  <= '0;
      wb_addr_q   <= '0;
      wb_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hold_ctrl_q <= hold_ctrl_d;
      hold_ds_q   <= hold_ds_d;
      hold_dt_q   <= hold_dt_d;
      hold_dd_q   <= hold_dd_d;
      hold_imm_q  <= hold_imm_d;
      wb_addr_q   <= wb_addr_d;
      wb_data_q   <= wb_data_d;
    end
  end

  // Outside EXEC the FPU sees a nop; operands stay on their flops to avoid toggling.
  assign bus.req_ready  = ready;
  assign bus.fpu_ctrl   = (state_q == S_EXEC) ? hold_ctrl_q : 4'd0;
  assign bus.fpu_ds_val = hold_ds_q;
  assign bus.fpu_dt_val = hold_dt_q;
  assign bus.fpu_dd     = hold_dd_q;
  assign bus.fpu_imm    = hold_imm_q;

  assign bus.wb_valid   = (state_q == S_WB) && (wb_addr_q != 6'd0);
  assign bus.wb_addr    = wb_addr_q;
  assign bus.wb_data    = wb_data_q;

  assign bus.pend_valid = (state_q == S_EXEC || state_q == S_WB) && (hold_dd_q != 6'd0) &&
                          (hold_ctrl_q != 4'd0) && (hold_ctrl_q != 4'd15);
  assign bus.pend_addr  = hold_dd_q;

endmodule

// File: tb/tb_fpu_issue.sv
// Directed bench for fpu_issue: writebacks are checked by a queue-driven monitor,
// cycle-level timing of control outputs by inline checks in the stimulus thread.
module tb_fpu_issue;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  typedef struct {
    logic [5:0]  addr;
    logic [31:0] data;
    int          at_cyc;
  } wb_exp_t;

  wb_exp_t exp_q[$];

  fpu_issue_if bus ();

  fpu_issue #(
    .LAT_ADD(2), .LAT_MUL(2), .LAT_INV(4), .LAT_SQRT(4), .LAT_CVT(2)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in FPU: nops report register 0; known vectors return their true IEEE results.
  function automatic logic [31:0] fpu_model(input logic [3:0] c, input logic [31:0] a,
                                            input logic [31:0] b);
    if (c == 4'd1 && a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
    if (c == 4'd1 && a == 32'h40000000 && b == 32'h40000000) return 32'h40800000;
    if (c == 4'd3 && a == 32'h40000000 && b == 32'h40400000) return 32'h40C00000;
    if (c == 4'd5 && a == 32'h40800000) return 32'h40000000;
    return a ^ b;
  endfunction

  assign bus.fpu_reg_addr = (bus.fpu_ctrl == 4'd0 || bus.fpu_ctrl == 4'd15) ? 6'd0 : bus.fpu_dd;
  assign bus.fpu_dd_val   = fpu_model(bus.fpu_ctrl, bus.fpu_ds_val, bus.fpu_dt_val);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rstn && bus.wb_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("spurious_wb_addr", {26'd0, bus.wb_addr}, 32'd0);
      end else begin
        wb_exp_t e;
        e = exp_q.pop_front();
        chk("wb_addr", {26'd0, bus.wb_addr}, {26'd0, e.addr});
        chk("wb_data", bus.wb_data, e.data);
        chk("wb_cycle", cyc, e.at_cyc);
      end
    end
  end

  // Called at a negedge; returns at the negedge of the first cycle after acceptance.
  task automatic issue(input logic [3:0] c, input logic [31:0] ds, input logic [31:0] dt,
                       input logic [5:0] dd, input logic [15:0] imm, input int lat,
                       input bit exp_wb, input logic [31:0] exp_data, output int acc);
    int n = 0;
    bus.req_valid  = 1'b1;
    bus.req_ctrl   = c;
    bus.req_ds_val = ds;
    bus.req_dt_val = dt;
    bus.req_dd     = dd;
    bus.req_imm    = imm;
    #1;
    while (bus.req_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (bus.req_ready !== 1'b1) chk("issue_timeout", {31'd0, bus.req_ready}, 32'd1);
    acc = cyc;
    if (exp_wb) exp_q.push_back('{addr: dd, data: exp_data, at_cyc: acc + lat + 1});
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    int a0, a1;
    bus.req_valid  = 1'b0;
    bus.req_ctrl   = 4'd0;
    bus.req_ds_val = 32'd0;
    bus.req_dt_val = 32'd0;
    bus.req_dd     = 6'd0;
    bus.req_imm    = 16'd0;
    bus.flush      = 1'b0;

    // Reset and idle
    #1;
    chk("rst_ready_low", {31'd0, bus.req_ready}, 32'd0);
    idle(3);
    rstn = 1'b1;
    idle(5);
    chk("idle_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("idle_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
    chk("idle_pend", {31'd0, bus.pend_valid}, 32'd0);
    chk("idle_fpu_ctrl", {28'd0, bus.fpu_ctrl}, 32'd0);

    // fadd 1.0 + 2.0 -> 3.0 into r5, latency 2
    issue(4'd1, 32'h3F800000, 32'h40000000, 6'd5, 16'h0123, 2, 1'b1, 32'h40400000, a0);
    chk("add_c1_ctrl", {28'd0, bus.fpu_ctrl}, 32'd1);
    chk("add_c1_ds", bus.fpu_ds_val, 32'h3F800000);
    chk("add_c1_dt", bus.fpu_dt_val, 32'h40000000);
    chk("add_c1_imm", {16'd0, bus.fpu_imm}, 32'h0123);
    chk("add_c1_pend", {31'd0, bus.pend_valid}, 32'd1);
    chk("add_c1_pend_addr", {26'd0, bus.pend_addr}, 32'd5);
    chk("add_c1_ready", {31'd0, bus.req_ready}, 32'd0);
    chk("add_c1_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
    @(negedge clk);
    chk("add_c2_ctrl", {28'd0, bus.fpu_ctrl}, 32'd1);
    chk("add_c2_pend", {31'd0, bus.pend_valid}, 32'd1);
    chk("add_c2_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
    @(negedge clk);
    chk("add_c3_wb_valid", {31'd0, bus.wb_valid}, 32'd1);
    chk("add_c3_pend", {31'd0, bus.pend_valid}, 32'd1);
    chk("add_c3_ctrl", {28'd0, bus.fpu_ctrl}, 32'd0);
    chk("add_c3_ready", {31'd0, bus.req_ready}, 32'd1);
    @(negedge clk);
    chk("add_c4_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
    chk("add_c4_pend", {31'd0, bus.pend_valid}, 32'd0);
    chk("add_c4_wb_addr_held", {26'd0, bus.wb_addr}, 32'd5);
    chk("add_c4_wb_data_held", bus.wb_data, 32'h40400000);
    idle(2);

    // Back-to-back: fmul 2.0*3.0 -> 6.0 offered during EXEC, accepted in the fadd's WB
    issue(4'd1, 32'h40000000, 32'h40000000, 6'd4, 16'd0, 2, 1'b1, 32'h40800000, a0);
    issue(4'd3, 32'h40000000, 32'h40400000, 6'd7, 16'd0, 2, 1'b1, 32'h40C00000, a1);
    chk("b2b_accept_cycle", a1, a0 + 3);
    idle(5);

    // finv flushed in its second EXEC cycle
    issue(4'd4, 32'h40000000, 32'd0, 6'd8, 16'd0, 4, 1'b0, 32'd0, a0);
    @(negedge clk);
    bus.flush = 1'b1;
    #1;
    chk("flush_c2_ready", {31'd0, bus.req_ready}, 32'd0);
    chk("flush_c2_pend", {31'd0, bus.pend_valid}, 32'd1);
    @(negedge clk);
    bus.flush = 1'b0;
    #1;
    chk("flush_c3_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("flush_c3_pend", {31'd0, bus.pend_valid}, 32'd0);
    chk("flush_c3_ctrl", {28'd0, bus.fpu_ctrl}, 32'd0);
    idle(6);

    // nop with a nonzero destination: one EXEC cycle, silent WB
    issue(4'd0, 32'h11111111, 32'h22222222, 6'd9, 16'd0, 1, 1'b0, 32'd0, a0);
    chk("nop_c1_ready", {31'd0, bus.req_ready}, 32'd0);
    chk("nop_c1_pend", {31'd0, bus.pend_valid}, 32'd0);
    @(negedge clk);
    chk("nop_c2_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("nop_c2_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
    chk("nop_c2_pend", {31'd0, bus.pend_valid}, 32'd0);
    idle(3);

    // fsub flushed during its WB: writeback still lands, the offered op is refused
    issue(4'd2, 32'h00000F0F, 32'h000000FF, 6'd6, 16'd0, 2, 1'b1, 32'h00000FF0, a0);
    idle(2);
    bus.flush      = 1'b1;
    bus.req_valid  = 1'b1;
    bus.req_ctrl   = 4'd3;
    bus.req_dd     = 6'd13;
    #1;
    chk("wbflush_ready", {31'd0, bus.req_ready}, 32'd0);
    chk("wbflush_wb_valid", {31'd0, bus.wb_valid}, 32'd1);
    @(negedge clk);
    bus.flush     = 1'b0;
    bus.req_valid = 1'b0;
    #1;
    chk("wbflush_next_ctrl", {28'd0, bus.fpu_ctrl}, 32'd0);
    chk("wbflush_next_pend", {31'd0, bus.pend_valid}, 32'd0);
    chk("wbflush_next_ready", {31'd0, bus.req_ready}, 32'd1);
    idle(2);

    // Valid together with flush in IDLE is not accepted
    bus.flush     = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_ctrl  = 4'd1;
    bus.req_dd    = 6'd14;
    #1;
    chk("vflush_ready", {31'd0, bus.req_ready}, 32'd0);
    @(negedge clk);
    bus.flush     = 1'b0;
    bus.req_valid = 1'b0;
    #1;
    chk("vflush_ctrl", {28'd0, bus.fpu_ctrl}, 32'd0);
    chk("vflush_pend", {31'd0, bus.pend_valid}, 32'd0);
    idle(3);

    // Asynchronous reset in the middle of fsqrt EXEC discards it
    issue(4'd5, 32'h40800000, 32'd0, 6'd11, 16'd0, 4, 1'b0, 32'd0, a0);
    @(negedge clk);
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_pend", {31'd0, bus.pend_valid}, 32'd0);
    chk("arst_ctrl", {28'd0, bus.fpu_ctrl}, 32'd0);
    chk("arst_ready", {31'd0, bus.req_ready}, 32'd0);
    chk("arst_wb_addr", {26'd0, bus.wb_addr}, 32'd0);
    idle(3);
    rstn = 1'b1;
    idle(6);
    chk("arst_after_wb_data", bus.wb_data, 32'd0);

    // fsqrt 4.0 -> 2.0 into r12 completes normally after the reset
    issue(4'd5, 32'h40800000, 32'd0, 6'd12, 16'd0, 4, 1'b1, 32'h40000000, a0);
    idle(8);

    chk("exp_queue_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
